dmem_store_buffer: RTL and testbench

- Write-back store buffer between the pipeline CPU data port (DAB/DDB/MemWrite/MemRead) and data_mem.
- CPU stores retire in one cycle into a small FIFO. Entries drain to data_mem in cycles when the memory port is otherwise free.
- Loads check the buffer first: the youngest matching store is forwarded; otherwise the load goes to memory.
- A flush handshake empties the buffer before halt or memory dump.

---
 rtl/dmem_store_buffer.sv | 134 +++++++++++++
 tb/tb_dmem_store_buffer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_store_buffer.sv
// Write-back store buffer between the CPU data port and data_mem, with load forwarding and flush.
// Optional hit/full-write statistics counters are built when STBUF_STATS_EN is defined.
module dmem_store_buffer #(
    parameter int WORD  = 64,
    parameter int AW    = 64,
    parameter int DEPTH = 4,
    parameter int PW    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cpu_MemWrite,
    input  logic            cpu_MemRead,
    input  logic [AW-1:0]   cpu_addr,
    input  logic [WORD-1:0] cpu_wdata,
    output logic [WORD-1:0] cpu_rdata,
    input  logic            flush_req,
    output logic            flush_done,
    output logic            mem_MemWrite,
    output logic            mem_MemRead,
    output logic [AW-1:0]   mem_addr,
    output logic [WORD-1:0] mem_wdata,
    input  logic [WORD-1:0] mem_rdata
`ifdef STBUF_STATS_EN
    ,
    output logic [31:0]     stat_fwd,
    output logic [31:0]     stat_fullwr
`endif
);

    localparam int TW = AW - 3;

    logic [TW-1:0]   r_tag  [DEPTH];
    logic [WORD-1:0] r_data [DEPTH];
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW:0]     r_count;

    logic            w_rd;
    logic            w_wr;
    logic            w_full;
    logic            w_empty;
    logic            w_hit;
    logic            w_miss;
    logic            w_drain;
    logic [WORD-1:0] w_fwd_data;
    logic [PW-1:0]   w_idx;

    // A simultaneous read and write is treated as a read; the store is dropped.
    assign w_rd    = rst_n && cpu_MemRead;
    assign w_wr    = rst_n && cpu_MemWrite && !cpu_MemRead;
    assign w_full  = (r_count == (PW+1)'(DEPTH));
    assign w_empty = (r_count == '0);

    // Walk oldest to youngest so the last match seen is the youngest store.
    always_comb begin
        w_hit      = 1'b0;
        w_fwd_data = '0;
        w_idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_rd_ptr + PW'(k);
            if (((PW+1)'(k) < r_count) && (r_tag[w_idx] == cpu_addr[AW-1:3])) begin
                w_hit      = 1'b1;
                w_fwd_data = r_data[w_idx];
            end
        end
    end

    assign w_miss  = w_rd && !w_hit;
    assign w_drain = rst_n && !w_empty && !w_miss &&
                     ((!cpu_MemRead && !cpu_MemWrite) || (w_wr && w_full) || flush_req);

    assign mem_MemRead  = w_miss;
    assign mem_MemWrite = w_drain;
    assign mem_addr     = w_miss ? cpu_addr : {r_tag[r_rd_ptr], 3'b000};
    assign mem_wdata    = r_data[r_rd_ptr];
    assign cpu_rdata    = !w_rd ? '0 : (w_hit ? w_fwd_data : mem_rdata);
    assign flush_done   = rst_n && flush_req && w_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_drain) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_wr, w_drain})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry payload carries no reset; validity comes from count and pointers.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_tag[r_wr_ptr]  <= cpu_addr[AW-1:3];
            r_data[r_wr_ptr] <= cpu_wdata;
        end
    end

`ifdef STBUF_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_fwd    <= '0;
            stat_fullwr <= '0;
        end else begin
            if (w_rd && w_hit) begin
                stat_fwd <= sat_inc(stat_fwd);
            end
            if (w_wr && w_full) begin
                stat_fullwr <= sat_inc(stat_fullwr);
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(cpu_MemWrite && cpu_MemRead))
            else $error("dmem_store_buffer: simultaneous load and store, store dropped");
        end
    end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Scoreboarded bench for dmem_store_buffer: expected memory writes are queued at store issue
// and popped when the buffer drains; loads are checked against an architectural memory image.
module tb_dmem_store_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_MemWrite, cpu_MemRead;
    logic [63:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        flush_req, flush_done;
    logic        mem_MemWrite, mem_MemRead;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
`ifdef STBUF_STATS_EN
    logic [31:0] stat_fwd, stat_fullwr;
`endif

    logic [63:0]  tbmem   [0:63];
    logic [63:0]  ref_mem [0:63];
    logic [127:0] exp_q [$];
    int           n_chk  = 0;
    int           n_fail = 0;
    logic         rn = 1'b0;
    logic         fl = 1'b0;

    always #5 clk = ~clk;

    dmem_store_buffer #(.WORD(64), .AW(64), .DEPTH(4), .PW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_MemWrite(cpu_MemWrite), .cpu_MemRead(cpu_MemRead),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .flush_req(flush_req), .flush_done(flush_done),
        .mem_MemWrite(mem_MemWrite), .mem_MemRead(mem_MemRead),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef STBUF_STATS_EN
        , .stat_fwd(stat_fwd), .stat_fullwr(stat_fullwr)
`endif
    );

    assign mem_rdata = tbmem[mem_addr[8:3]];

    always @(posedge clk) begin
        if (rst_n && mem_MemWrite) tbmem[mem_addr[8:3]] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Every drain must match the oldest outstanding store, in program order.
    always @(negedge clk) begin
        logic [127:0] e;
        if (mem_MemWrite) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            check("drain_addr", mem_addr, e[127:64]);
            check("drain_data", mem_wdata, e[63:0]);
        end
    end

    task automatic step(input logic wr, input logic rd, input logic [63:0] a, input logic [63:0] d);
        @(posedge clk);
        #1;
        rst_n        = rn;
        flush_req    = fl;
        cpu_MemWrite = wr;
        cpu_MemRead  = rd;
        cpu_addr     = a;
        cpu_wdata    = d;
        if (wr && !rd && rn) begin
            exp_q.push_back({a, d});
            ref_mem[a[8:3]] = d;
        end
        @(negedge clk);
        if (rd && rn) check("ld_data", cpu_rdata, ref_mem[a[8:3]]);
    endtask

    task automatic st(input logic [63:0] a, input logic [63:0] d);
        step(1'b1, 1'b0, a, d);
    endtask

    task automatic ld(input logic [63:0] a);
        step(1'b0, 1'b1, a, 64'd0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 64'd0, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            tbmem[i]   = 64'hC0DE_0000_0000_0000 | 64'(i);
            ref_mem[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
        end
        tbmem[8]   = 64'h55;
        ref_mem[8] = 64'h55;
        rst_n = 1'b0; flush_req = 1'b0; cpu_MemWrite = 1'b0; cpu_MemRead = 1'b0;
        cpu_addr = '0; cpu_wdata = '0;

        // Reset with a load and flush request pending: everything gated low.
        rn = 1'b0; fl = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 64'h10, 64'd0);
            check("rst_rdata", cpu_rdata, 64'd0);
            check("rst_memrd", 64'(mem_MemRead), 64'd0);
            check("rst_memwr", 64'(mem_MemWrite), 64'd0);
            check("rst_fdone", 64'(flush_done), 64'd0);
        end
        rn = 1'b1; fl = 1'b0;

        // Store then forward, drain on next idle cycle.
        st(64'h10, 64'hAAAA);
        check("t1_st_memwr", 64'(mem_MemWrite), 64'd0);
        ld(64'h10);
        check("t1_ld_rdata", cpu_rdata, 64'hAAAA);
        check("t1_ld_memrd", 64'(mem_MemRead), 64'd0);
        check("t1_ld_memwr", 64'(mem_MemWrite), 64'd0);
        idle();
        check("t1_drain_wr", 64'(mem_MemWrite), 64'd1);
        check("t1_drain_addr", mem_addr, 64'h10);
        idle();
        check("t1_quiet", 64'(mem_MemWrite), 64'd0);

        // Youngest of two same-address stores is forwarded; both drain in order.
        st(64'h20, 64'h1);
        st(64'h20, 64'h2);
        ld(64'h20);
        check("t2_fwd_young", cpu_rdata, 64'h2);
        check("t2_memrd", 64'(mem_MemRead), 64'd0);
        idle();
        idle();
        idle();
        check("t2_mem", tbmem[4], 64'h2);
        check("t2_quiet", 64'(mem_MemWrite), 64'd0);

        // Fill to DEPTH, fifth store drains head in the same cycle.
        for (int i = 0; i < 4; i++) begin
            st(64'(i * 8), 64'h3000 + 64'(i));
            check("t3_fill_nowr", 64'(mem_MemWrite), 64'd0);
        end
        st(64'h20, 64'h3004);
        check("t3_full_wr", 64'(mem_MemWrite), 64'd1);
        check("t3_full_addr", mem_addr, 64'h00);
`ifdef STBUF_STATS_EN
        check("t3_stat_fullwr", 64'(stat_fullwr), 64'd1);
        check("t3_stat_fwd", 64'(stat_fwd), 64'd2);
`endif
        fl = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle();
            check("t3_fl_done", 64'(flush_done), 64'd0);
            check("t3_fl_wr", 64'(mem_MemWrite), 64'd1);
            check("t3_fl_addr", mem_addr, 64'(8 + i * 8));
        end
        idle();
        check("t3_fl_done_end", 64'(flush_done), 64'd1);
        check("t3_fl_nowr", 64'(mem_MemWrite), 64'd0);
        fl = 1'b0;

        // Load miss takes the port; drain deferred to next idle.
        st(64'h08, 64'h0808);
        ld(64'h40);
        check("t4_miss_rdata", cpu_rdata, 64'h55);
        check("t4_miss_memrd", 64'(mem_MemRead), 64'd1);
        check("t4_miss_addr", mem_addr, 64'h40);
        check("t4_miss_nowr", 64'(mem_MemWrite), 64'd0);
        idle();
        check("t4_drain_wr", 64'(mem_MemWrite), 64'd1);
        check("t4_drain_addr", mem_addr, 64'h08);

        // Flush three entries; then a store during flush delays done.
        st(64'h48, 64'h48); st(64'h50, 64'h50); st(64'h58, 64'h58);
        fl = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle();
            check("t5_done_lo", 64'(flush_done), 64'd0);
            check("t5_drain", 64'(mem_MemWrite), 64'd1);
        end
        idle();
        check("t5_done_hi", 64'(flush_done), 64'd1);
        st(64'h60, 64'h60);
        check("t5_st_done", 64'(flush_done), 64'd1);
        check("t5_st_nowr", 64'(mem_MemWrite), 64'd0);
        idle();
        check("t5_redone_lo", 64'(flush_done), 64'd0);
        check("t5_redrain", mem_addr, 64'h60);
        idle();
        check("t5_redone_hi", 64'(flush_done), 64'd1);
        fl = 1'b0;

        // Reset discards buffered stores.
        st(64'h68, 64'h6868); st(64'h70, 64'h7070);
        rn = 1'b0;
        idle();
        check("t6_rst_nowr", 64'(mem_MemWrite), 64'd0);
        exp_q.delete();
        for (int i = 0; i < 64; i++) ref_mem[i] = tbmem[i];
        rn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle();
            check("t6_nowr", 64'(mem_MemWrite), 64'd0);
        end
        ld(64'h68);
        check("t6_ld_memrd", 64'(mem_MemRead), 64'd1);
        ld(64'h70);
        check("t6_ld2_memrd", 64'(mem_MemRead), 64'd1);

        // Random mix of loads, stores, idles and flush over a small address window.
        for (int i = 0; i < 300; i++) begin
            int unsigned op;
            logic [63:0] a;
            op = $urandom_range(0, 3);
            a  = 64'(($urandom_range(0, 7) + 16) * 8);
            fl = ($urandom_range(0, 7) == 0);
            case (op)
                0, 3:    st(a, {32'hF00D, 32'($urandom)});
                1:       ld(a);
                default: idle();
            endcase
        end
        fl = 1'b1;
        begin
            int n = 0;
            do begin
                idle();
                n++;
            end while (!flush_done && n < 20);
        end
        check("final_flush_done", 64'(flush_done), 64'd1);
        fl = 1'b0;
        idle();
        check("final_q_empty", 64'(exp_q.size()), 64'd0);
        for (int i = 0; i < 64; i++) check("final_mem", tbmem[i], ref_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
